// File: rtl/ping_pong_pkg.sv
// ============================================================================
// ping_pong_pkg : shared types and constants for the two-ball ping-pong model
// Revision: 1.0
// ============================================================================
`default_nettype none

package ping_pong_pkg;

    typedef enum logic {
        ACT_HIT  = 1'b0,
        ACT_IDLE = 1'b1
    } action_type;

    typedef enum logic [1:0] {
        PS_HIT          = 2'd0,
        PS_WAIT_GOING   = 2'd1,
        PS_WAIT_COMING  = 2'd2
    } player_status;

    typedef enum logic [1:0] {
        BALL_TO_A = 2'd0,
        BALL_TO_B = 2'd1,
        BALL_OUT  = 2'd2
    } ball_status;

    typedef enum logic [1:0] {
        PH_RALLY2 = 2'd0,
        PH_RALLY1 = 2'd1,
        PH_FAULT  = 2'd2
    } ref_phase;

    localparam logic [2:0] ERR_NONE      = 3'd0;
    localparam logic [2:0] ERR_BAD_ENC   = 3'd1;
    localparam logic [2:0] ERR_BOTH_OUT  = 3'd2;
    localparam logic [2:0] ERR_REENTRY   = 3'd3;
    localparam logic [2:0] ERR_WAIT_GOING_INCOMING = 3'd4;
    localparam logic [2:0] ERR_STALL     = 3'd5;

    localparam logic [1:0] DROP_NONE  = 2'd0;
    localparam logic [1:0] DROP_BALL1 = 2'd1;
    localparam logic [1:0] DROP_BALL2 = 2'd2;

    // causes[0] is the highest-priority cause (code 1)
    function automatic logic [2:0] first_fault(input logic [4:0] causes);
        logic [2:0] code;
        code = ERR_NONE;
        for (int i = 4; i >= 0; i--) begin
            if (causes[i]) code = 3'(i + 1);
        end
        return code;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter with synchronous clear and freeze
// Revision: 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W   = 8,
    parameter int MAX = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    input  logic         hold,
    output logic [W-1:0] count
);

    localparam logic [W-1:0] c_max = W'(MAX);

    logic [W-1:0] r_count;

    // hold dominates clear so a frozen counter cannot be disturbed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (hold) begin
            r_count <= r_count;
        end else if (clr) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/ping_pong_referee.sv
// ============================================================================
// ping_pong_referee : game-phase tracker, hit counters and sticky fault latch
// Revision: 1.0
// ============================================================================
`default_nettype none

module ping_pong_referee
    import ping_pong_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int STALL_MAX = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             action_a,
    input  logic             action_b,
    input  logic [1:0]       state_a,
    input  logic [1:0]       state_b,
    input  logic [1:0]       state_ball_1,
    input  logic [1:0]       state_ball_2,
    output logic [1:0]       phase,
    output logic [1:0]       dropped_ball,
    output logic [CNT_W-1:0] hits_a,
    output logic [CNT_W-1:0] hits_b,
    output logic             err,
    output logic [2:0]       err_code
);

    localparam int              STALL_W      = $clog2(STALL_MAX + 1);
    localparam logic [STALL_W-1:0] c_stall_last = STALL_W'(STALL_MAX - 1);

    ref_phase     r_phase;
    ref_phase     w_phase_nxt;
    logic [1:0]   r_dropped;
    logic [1:0]   w_dropped_nxt;
    logic [2:0]   r_err_code;
    logic [2:0]   w_err_code_nxt;

    logic               w_hit_a;
    logic               w_hit_b;
    logic               w_any_hit;
    logic               w_frozen;
    logic [STALL_W-1:0] w_stall_cnt;
    logic               w_b1_out;
    logic               w_b2_out;
    logic [4:0]         w_causes;
    logic               w_fault;

    assign w_hit_a   = (action_a == ACT_HIT);
    assign w_hit_b   = (action_b == ACT_HIT);
    assign w_any_hit = w_hit_a || w_hit_b;
    assign w_frozen  = (r_phase == PH_FAULT);
    assign w_b1_out  = (state_ball_1 == BALL_OUT);
    assign w_b2_out  = (state_ball_2 == BALL_OUT);

    sat_counter #(.W(CNT_W), .MAX((2 ** CNT_W) - 1)) u_hits_a (
        .clk(clk), .rst_n(rst_n), .inc(w_hit_a), .clr(1'b0), .hold(w_frozen), .count(hits_a)
    );

    sat_counter #(.W(CNT_W), .MAX((2 ** CNT_W) - 1)) u_hits_b (
        .clk(clk), .rst_n(rst_n), .inc(w_hit_b), .clr(1'b0), .hold(w_frozen), .count(hits_b)
    );

    sat_counter #(.W(STALL_W), .MAX(STALL_MAX)) u_stall (
        .clk(clk), .rst_n(rst_n), .inc(!w_any_hit), .clr(w_any_hit), .hold(w_frozen),
        .count(w_stall_cnt)
    );

    // Stall fires on the sample that would carry the counter to STALL_MAX
    assign w_causes[0] = (state_a == 2'd3) || (state_b == 2'd3) ||
                         (state_ball_1 == 2'd3) || (state_ball_2 == 2'd3);
    assign w_causes[1] = w_b1_out && w_b2_out;
    assign w_causes[2] = ((r_dropped == DROP_BALL1) && !w_b1_out) ||
                         ((r_dropped == DROP_BALL2) && !w_b2_out);
    assign w_causes[3] = ((state_a == PS_WAIT_GOING) &&
                          ((state_ball_1 == BALL_TO_A) || (state_ball_2 == BALL_TO_A))) ||
                         ((state_b == PS_WAIT_GOING) &&
                          ((state_ball_1 == BALL_TO_B) || (state_ball_2 == BALL_TO_B)));
    assign w_causes[4] = !w_any_hit && (w_stall_cnt >= c_stall_last);
    assign w_fault     = |w_causes;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_phase    <= PH_RALLY2;
            r_dropped  <= DROP_NONE;
            r_err_code <= ERR_NONE;
        end else begin
            r_phase    <= w_phase_nxt;
            r_dropped  <= w_dropped_nxt;
            r_err_code <= w_err_code_nxt;
        end
    end

    always_comb begin
        w_phase_nxt    = r_phase;
        w_dropped_nxt  = r_dropped;
        w_err_code_nxt = r_err_code;
        case (r_phase)
            PH_RALLY2: begin
                if (w_b1_out != w_b2_out) begin
                    w_phase_nxt   = PH_RALLY1;
                    w_dropped_nxt = w_b1_out ? DROP_BALL1 : DROP_BALL2;
                end
                if (w_fault) begin
                    w_phase_nxt    = PH_FAULT;
                    w_err_code_nxt = first_fault(w_causes);
                end
            end
            PH_RALLY1: begin
                if (w_fault) begin
                    w_phase_nxt    = PH_FAULT;
                    w_err_code_nxt = first_fault(w_causes);
                end
            end
            PH_FAULT: begin
                w_phase_nxt = PH_FAULT;
            end
            default: begin
                w_phase_nxt = PH_FAULT;
            end
        endcase
    end

    assign phase        = r_phase;
    assign dropped_ball = r_dropped;
    assign err          = (r_phase == PH_FAULT);
    assign err_code     = r_err_code;

endmodule

`default_nettype wire
